// File: rtl/gpu_copyvc_stream_if.sv
// gpu_copyvc_stream_if: CPU-side and DDR-side signal bundle of the VRAM->CPU copy engine.
// master = copy engine (drives o_*), slave = CPU/DDR environment (drives i_* and Reg*).
// Optional o_stallCnt is present only when GPU_COPYVC_PERFCNT_EN is defined.
interface gpu_copyvc_stream_if #(
    parameter int PIX_PER_WORD = 2
);
    localparam int OUT_W = 16 * PIX_PER_WORD;

    // start command
    logic                 i_activate;
    logic [11:0]          RegX0;
    logic [11:0]          RegY0;
    logic [10:0]          RegSizeW;
    logic [9:0]           RegSizeH;
    // CPU read port
    logic                 i_popPixelPair;
    logic                 o_validOut;
    logic [OUT_W-1:0]     o_dataOut;
    logic                 o_exitSig;
    logic                 o_active;
    // DDR read port
    logic                 o_command;
    logic                 i_busy;
    logic [1:0]           o_commandSize;
    logic                 o_write;
    logic [14:0]          o_adr;
    logic [2:0]           o_subadr;
    logic [255:0]         i_dataIn;
    logic                 i_dataInValid;
`ifdef GPU_COPYVC_PERFCNT_EN
    logic [15:0]          o_stallCnt;
`endif

    modport master (
`ifdef GPU_COPYVC_PERFCNT_EN
        output o_stallCnt,
`endif
        input  i_activate, RegX0, RegY0, RegSizeW, RegSizeH,
        input  i_popPixelPair, i_busy, i_dataIn, i_dataInValid,
        output o_validOut, o_dataOut, o_exitSig, o_active,
        output o_command, o_commandSize, o_write, o_adr, o_subadr
    );

    modport slave (
`ifdef GPU_COPYVC_PERFCNT_EN
        input  o_stallCnt,
`endif
        output i_activate, RegX0, RegY0, RegSizeW, RegSizeH,
        output i_popPixelPair, i_busy, i_dataIn, i_dataInValid,
        input  o_validOut, o_dataOut, o_exitSig, o_active,
        input  o_command, o_commandSize, o_write, o_adr, o_subadr
    );
endinterface

// File: rtl/gpu_copyvc_stream.sv
// gpu_copyvc_stream: VRAM->CPU rectangle copy; 32-byte DDR reads unpacked row-major, PIX_PER_WORD pixels per FIFO word.
// Latency: one read outstanding; request -> data -> one pixel per cycle into packer; output word visible the cycle after push.
// Backpressure: reads issued only with room for a full line in the FIFO; i_busy holds the request; CPU pops at will.
// Ports: i_clk, i_rst (sync, active high), bus (gpu_copyvc_stream_if.master: start regs, CPU pop port, DDR read port).
// Optional: define GPU_COPYVC_PERFCNT_EN to add o_stallCnt (saturating count of blocked request cycles).
module gpu_copyvc_stream #(
    parameter int PIX_PER_WORD = 2,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    gpu_copyvc_stream_if.master bus
);
    localparam int OUT_W      = 16 * PIX_PER_WORD;
    localparam int PW         = $clog2(PIX_PER_WORD);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int LINE_WORDS = 16 / PIX_PER_WORD;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_PAD, S_DONE} state_t;

    state_t             state;
    logic [9:0]         x0;
    logic [8:0]         y0;
    logic [9:0]         w_m1;       // effective width - 1
    logic [8:0]         h_m1;       // effective height - 1
    logic [10:0]        col;
    logic [9:0]         row;
    logic [255:0]       line;
    logic [PW-1:0]      pk_cnt;
    logic [OUT_W-1:0]   pk_dat;

    logic [OUT_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        fcnt;

    logic [9:0]         cur_x;
    logic [8:0]         cur_y;
    logic [15:0]        pix;
    logic [OUT_W-1:0]   pk_nxt;
    logic               pk_full;
    logic               last_col;
    logic               last_row;
    logic               free_ok;
    logic               cmd_ok;
    logic               req_acc;
    logic               fifo_full;
    logic               push_vld;
    logic [OUT_W-1:0]   push_dat;
    logic               pop;
    logic               unused_bits;

    // Register bits above the VRAM coordinate range do not participate.
    assign unused_bits = ^{bus.RegX0[11:10], bus.RegY0[11:9], bus.RegSizeW[10], bus.RegSizeH[9]};

    // Coordinates wrap naturally through the 10/9-bit adders.
    assign cur_x    = x0 + col[9:0];
    assign cur_y    = y0 + row[8:0];
    assign pix      = line[{cur_x[3:0], 4'd0} +: 16];
    assign pk_nxt   = pk_dat | (OUT_W'(pix) << {pk_cnt, 4'd0});
    assign pk_full  = (pk_cnt == PW'(PIX_PER_WORD - 1));
    assign last_col = (col == {1'b0, w_m1});
    assign last_row = (row == {1'b0, h_m1});

    assign fifo_full = (fcnt == (AW+1)'(FIFO_DEPTH));
    assign free_ok   = (fcnt <= (AW+1)'(FIFO_DEPTH - LINE_WORDS));
    assign cmd_ok    = (state == S_REQ) && free_ok;
    assign req_acc   = cmd_ok && !bus.i_busy;
    assign pop       = bus.i_popPixelPair && (fcnt != '0);

    always_comb begin
        push_vld = 1'b0;
        push_dat = pk_nxt;
        if (state == S_DRAIN && pk_full) begin
            push_vld = 1'b1;
        end else if (state == S_PAD && !fifo_full) begin
            push_vld = 1'b1;
            push_dat = pk_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fcnt <= fcnt + (AW+1)'(push_vld) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            x0     <= '0;
            y0     <= '0;
            w_m1   <= '0;
            h_m1   <= '0;
            col    <= '0;
            row    <= '0;
            line   <= '0;
            pk_cnt <= '0;
            pk_dat <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_activate) begin
                        x0     <= bus.RegX0[9:0];
                        y0     <= bus.RegY0[8:0];
                        // 0 wraps to all-ones, i.e. full 1024 / 512
                        w_m1   <= bus.RegSizeW[9:0] - 10'd1;
                        h_m1   <= bus.RegSizeH[8:0] - 9'd1;
                        col    <= '0;
                        row    <= '0;
                        pk_cnt <= '0;
                        pk_dat <= '0;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_acc) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.i_dataInValid) begin
                        line  <= bus.i_dataIn;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Rows run straight on in the packer; no per-row alignment.
                    if (pk_full) begin
                        pk_cnt <= '0;
                        pk_dat <= '0;
                    end else begin
                        pk_cnt <= pk_cnt + PW'(1);
                        pk_dat <= pk_nxt;
                    end
                    if (last_col) begin
                        col <= '0;
                        row <= row + 10'd1;
                        if (last_row) begin
                            state <= pk_full ? S_DONE : S_PAD;
                        end else begin
                            state <= S_REQ;
                        end
                    end else begin
                        col <= col + 11'd1;
                        if (cur_x[3:0] == 4'hF) begin
                            state <= S_REQ;
                        end
                    end
                end
                S_PAD: begin
                    // A straddling final line can yield one word beyond the
                    // line reservation, so the pad word waits for a free slot.
                    if (!fifo_full) begin
                        pk_cnt <= '0;
                        pk_dat <= '0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GPU_COPYVC_PERFCNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && bus.i_activate) begin
            stall_cnt <= '0;
        end else if (state == S_REQ && !req_acc && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.o_stallCnt = stall_cnt;
`endif

    // All outputs decode registered state only.
    assign bus.o_validOut    = (fcnt != '0);
    assign bus.o_dataOut     = (fcnt != '0) ? mem[rd_ptr] : '0;
    assign bus.o_exitSig     = (state == S_DONE);
    assign bus.o_active      = (state != S_IDLE);
    assign bus.o_command     = cmd_ok;
    assign bus.o_commandSize = 2'd1;
    assign bus.o_write       = 1'b0;
    assign bus.o_adr         = {cur_y, cur_x[9:4]};
    assign bus.o_subadr      = 3'd0;
endmodule
